// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single-ported SRAM. Each transfer occupies the SRAM for WAIT_CYCLES cycles
// and is followed by a one-cycle completion pulse.
// Optional build macro: ARB_PERF_CNT_EN adds a 32-bit stall-cycle counter
// on perf_stall_cycles. Without it, perf_stall_cycles is tied to 0.
module mem_arbiter #(
   parameter int WAIT_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        sram_en,
   output logic        sram_we,
   output logic [15:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic        freeze,
   output logic [31:0] perf_stall_cycles
);

   localparam logic [3:0] LP_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic        r_last_mem;
   logic        r_grant_mem;
   logic [15:0] r_addr;
   logic        r_we;
   logic [31:0] r_wdata;
   logic [31:0] r_if_rdata;
   logic [31:0] r_mem_rdata;
   logic        w_grant_mem;
   logic        w_any_req;
   logic        w_unused;

   // Word-address bits outside [17:2] carry no meaning for the SRAM.
   assign w_unused = ^{if_addr[31:18], if_addr[1:0], mem_addr[31:18], mem_addr[1:0]};

   assign w_any_req = if_req | mem_req;

   // Arbitration: data port wins a tie unless it also won the previous grant.
   always_comb begin
      w_grant_mem = 1'b0;
      if (mem_req && (!if_req || !r_last_mem)) begin
         w_grant_mem = 1'b1;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_any_req) w_next_state = ACCESS;
         ACCESS:  if (r_cnt == '0) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // Request latching, wait counter and read-data capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_last_mem  <= 1'b0;
         r_grant_mem <= 1'b0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_grant_mem <= w_grant_mem;
                  r_last_mem  <= w_grant_mem;
                  r_addr      <= w_grant_mem ? mem_addr[17:2] : if_addr[17:2];
                  r_we        <= w_grant_mem & mem_we;
                  r_wdata     <= w_grant_mem ? mem_wdata : '0;
                  r_cnt       <= LP_LOAD;
               end
            end
            ACCESS: begin
               if (r_cnt == '0) begin
                  if (r_grant_mem) r_mem_rdata <= sram_rdata;
                  else             r_if_rdata  <= sram_rdata;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sram_en    = (r_state == ACCESS);
   assign sram_we    = (r_state == ACCESS) & r_we;
   assign sram_addr  = r_addr;
   assign sram_wdata = r_wdata;

   assign if_ready   = (r_state == DONE) & ~r_grant_mem;
   assign mem_ready  = (r_state == DONE) &  r_grant_mem;
   assign if_rdata   = r_if_rdata;
   assign mem_rdata  = r_mem_rdata;

   assign freeze = (if_req & ~if_ready) | (mem_req & ~mem_ready);

`ifdef ARB_PERF_CNT_EN
   logic [31:0] r_perf_cnt;

   // Stall-cycle counter, wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (rst)         r_perf_cnt <= '0;
      else if (freeze) r_perf_cnt <= r_perf_cnt + 32'd1;
   end

   assign perf_stall_cycles = r_perf_cnt;
`else
   assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter (WAIT_CYCLES=3) with a
// cycle-timeline reference model checked every cycle, plus literal checks.
module tb_mem_arbiter;

   localparam int W = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        sram_en;
   logic        sram_we;
   logic [15:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        freeze;
   logic [31:0] perf_stall_cycles;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   mem_arbiter #(.WAIT_CYCLES(W)) dut (
      .clk               (clk),
      .rst               (rst),
      .if_req            (if_req),
      .if_addr           (if_addr),
      .if_rdata          (if_rdata),
      .if_ready          (if_ready),
      .mem_req           (mem_req),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_rdata         (mem_rdata),
      .mem_ready         (mem_ready),
      .sram_en           (sram_en),
      .sram_we           (sram_we),
      .sram_addr         (sram_addr),
      .sram_wdata        (sram_wdata),
      .sram_rdata        (sram_rdata),
      .freeze            (freeze),
      .perf_stall_cycles (perf_stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: a transfer accepted in cycle s occupies the SRAM in
   // cycles s+1..s+W, captures read data in cycle s+W and completes in s+W+1.
   bit          m_ok = 1'b0;
   bit          m_busy = 1'b0;
   int          m_start = 0;
   bit          m_gmem = 1'b0;
   bit          m_last_mem = 1'b0;
   bit          m_we = 1'b0;
   logic [15:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_if_rd = '0;
   logic [31:0] m_mem_rd = '0;
   logic [31:0] m_perf = '0;

   function automatic bit e_access();
      return m_busy && (cyc >= m_start + 1) && (cyc <= m_start + W);
   endfunction

   function automatic bit e_done();
      return m_busy && (cyc == m_start + W + 1);
   endfunction

   function automatic bit e_freeze();
      return (if_req && !(e_done() && !m_gmem)) || (mem_req && !(e_done() && m_gmem));
   endfunction

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_ok       = 1'b1;
         m_busy     = 1'b0;
         m_last_mem = 1'b0;
         m_if_rd    = '0;
         m_mem_rd   = '0;
         m_perf     = '0;
      end else begin
`ifdef ARB_PERF_CNT_EN
         if (e_freeze()) m_perf = m_perf + 32'd1;
`endif
         if (!m_busy) begin
            if (if_req || mem_req) begin
               m_gmem     = mem_req && !(if_req && m_last_mem);
               m_last_mem = m_gmem;
               m_busy     = 1'b1;
               m_start    = cyc;
               m_addr     = m_gmem ? mem_addr[17:2] : if_addr[17:2];
               m_we       = m_gmem && mem_we;
               m_wdata    = mem_wdata;
            end
         end else if (cyc == m_start + W) begin
            if (m_gmem) m_mem_rd = sram_rdata;
            else        m_if_rd  = sram_rdata;
         end else if (cyc == m_start + W + 1) begin
            m_busy = 1'b0;
         end
      end
      cyc++;
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (m_ok) begin
         chk("m_if_ready", if_ready, e_done() && !m_gmem);
         chk("m_mem_ready", mem_ready, e_done() && m_gmem);
         chk("m_sram_en", sram_en, e_access());
         chk("m_sram_we", sram_we, e_access() && m_we);
         if (e_access()) chk("m_sram_addr", sram_addr, m_addr);
         if (e_access() && m_we) chk("m_sram_wdata", sram_wdata, m_wdata);
         chk("m_if_rdata", if_rdata, m_if_rd);
         chk("m_mem_rdata", mem_rdata, m_mem_rd);
         chk("m_freeze", freeze, e_freeze());
         chk("m_perf", perf_stall_cycles, m_perf);
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
      mem_addr = '0; mem_wdata = '0; sram_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_mem_ready", mem_ready, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_mem_rdata", mem_rdata, 0);
      chk("rst_sram_en", sram_en, 0);
      chk("rst_sram_we", sram_we, 0);
      chk("rst_perf", perf_stall_cycles, 0);
      nxt(); rst = 1'b0;

      // Single instruction fetch.
      nxt(); if_req = 1'b1; if_addr = 32'h0000_0008; sram_rdata = 32'hE3A0_0001;
      @(negedge clk);
      chk("if_idle_en", sram_en, 0);
      for (int k = 1; k <= 3; k++) begin
         nxt(); @(negedge clk);
         chk("if_acc_en", sram_en, 1);
         chk("if_acc_addr", sram_addr, 16'h0002);
         chk("if_acc_we", sram_we, 0);
         chk("if_early_ready", if_ready, 0);
      end
      nxt(); @(negedge clk);
      chk("if_ready", if_ready, 1);
      chk("if_rdata", if_rdata, 32'hE3A0_0001);
      chk("if_done_en", sram_en, 0);
      nxt(); if_req = 1'b0; sram_rdata = 32'h0;
      @(negedge clk);
      chk("if_ready_once", if_ready, 0);
      chk("if_rdata_hold", if_rdata, 32'hE3A0_0001);
`ifdef ARB_PERF_CNT_EN
      chk("perf_if_read", perf_stall_cycles, 4);
`else
      chk("perf_if_read", perf_stall_cycles, 0);
`endif

      // Data write.
      nxt(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0404;
      mem_wdata = 32'hDEAD_BEEF; sram_rdata = 32'h1234_5678;
      @(negedge clk);
      for (int k = 1; k <= 3; k++) begin
         nxt(); @(negedge clk);
         chk("wr_en", sram_en, 1);
         chk("wr_we", sram_we, 1);
         chk("wr_addr", sram_addr, 16'h0101);
         chk("wr_wdata", sram_wdata, 32'hDEAD_BEEF);
      end
      nxt(); @(negedge clk);
      chk("wr_mem_ready", mem_ready, 1);
      chk("wr_if_ready", if_ready, 0);
      chk("wr_mem_rdata", mem_rdata, 32'h1234_5678);
      nxt(); mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      chk("wr_ready_once", mem_ready, 0);

      // Both requesters held from reset: alternating grants.
      nxt(); rst = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0100;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0200;
      nxt(); rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) nxt();
         sram_rdata = 32'hA500_0000 | 32'(k);
         @(negedge clk);
         if (k == 0) begin
            chk("rr_rst_if_rdata", if_rdata, 0);
            chk("rr_rst_mem_rdata", mem_rdata, 0);
         end
         chk("rr_mem_ready", mem_ready, (k == 4) || (k == 14));
         chk("rr_if_ready", if_ready, (k == 9) || (k == 19));
         if (k == 2)  chk("rr_addr_mem", sram_addr, 16'h0080);
         if (k == 7)  chk("rr_addr_if", sram_addr, 16'h0040);
         if (k == 4)  chk("rr_mem_rdata1", mem_rdata, 32'hA500_0003);
         if (k == 9)  chk("rr_if_rdata1", if_rdata, 32'hA500_0008);
         if (k == 14) chk("rr_mem_rdata2", mem_rdata, 32'hA500_000D);
         if (k == 19) chk("rr_if_rdata2", if_rdata, 32'hA500_0012);
      end
      nxt(); if_req = 1'b0; mem_req = 1'b0;

      // Reset during the second access cycle.
      nxt(); if_req = 1'b1; if_addr = 32'h0000_0010; sram_rdata = 32'h5555_AAAA;
      nxt();
      nxt(); rst = 1'b1; if_req = 1'b0;
      @(negedge clk);
      chk("abort_acc2_en", sram_en, 1);
      nxt(); rst = 1'b0;
      @(negedge clk);
      chk("abort_en", sram_en, 0);
      for (int k = 0; k < 5; k++) begin
         nxt(); @(negedge clk);
         chk("abort_if_ready", if_ready, 0);
         chk("abort_mem_ready", mem_ready, 0);
         chk("abort_if_rdata", if_rdata, 0);
      end
      nxt(); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'hFFFF_FFFF; sram_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      for (int k = 1; k <= 3; k++) begin
         nxt(); @(negedge clk);
         chk("post_en", sram_en, 1);
         chk("post_addr", sram_addr, 16'hFFFF);
         chk("post_we", sram_we, 0);
      end
      nxt(); @(negedge clk);
      chk("post_mem_ready", mem_ready, 1);
      chk("post_mem_rdata", mem_rdata, 32'hCAFE_F00D);
      nxt(); mem_req = 1'b0;

      // Data request withdrawn after the first access cycle.
      nxt(); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0040; sram_rdata = 32'h0BAD_CAFE;
      nxt();
      nxt(); mem_req = 1'b0;
      @(negedge clk);
      chk("drop_en2", sram_en, 1);
      chk("drop_addr", sram_addr, 16'h0010);
      nxt(); @(negedge clk);
      chk("drop_en3", sram_en, 1);
      nxt(); @(negedge clk);
      chk("drop_mem_ready", mem_ready, 1);
      chk("drop_mem_rdata", mem_rdata, 32'h0BAD_CAFE);
      for (int k = 0; k < 3; k++) begin
         nxt(); @(negedge clk);
         chk("drop_idle_ready", mem_ready, 0);
         chk("drop_idle_en", sram_en, 0);
      end

      nxt();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
